// File: rtl/bcd_display_mux.sv
// Two-digit multiplexed seven-segment driver for the dice-roller result.
// Captures the roller's BCD value once per frame, then scans it onto a shared segment bus.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// BLANK0    | all digits off; bcd_in/blank_lz latched on its first cycle
// SHOW_ONES | an=01, ones digit lit, dp flashes after a value change
// BLANK1    | all digits off, ghost suppression between digits
// SHOW_TENS | an=10, tens digit lit, optional leading-zero blanking
module bcd_display_mux #(
   parameter int SCAN_DIV     = 16,
   parameter int GUARD        = 2,
   parameter int FLASH_FRAMES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] bcd_in,
   input  logic       blank_lz,
   output logic [6:0] seg,
   output logic       dp,
   output logic [1:0] an
);

   localparam int MAXLEN = (SCAN_DIV > GUARD) ? SCAN_DIV : GUARD;
   localparam int CW     = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

   localparam logic [CW-1:0] GUARD_LD = CW'(GUARD - 1);
   localparam logic [CW-1:0] SCAN_LD  = CW'(SCAN_DIV - 1);
   localparam logic [7:0]    FLASH_LD = 8'(FLASH_FRAMES);

   typedef enum logic [1:0] {
      BLANK0    = 2'd0,
      SHOW_ONES = 2'd1,
      BLANK1    = 2'd2,
      SHOW_TENS = 2'd3
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;

   logic [7:0] shown;
   logic       lz_q;
   logic [7:0] flash_cnt;
   logic       first_q;
   logic       latch;
   logic       tens_blank;

   function automatic logic [6:0] seg7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h40;
      endcase
      return s;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= BLANK0;
         cnt   <= GUARD_LD;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // One shared down-counter times every slot; it reloads on each state change.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt - CW'(1);
      if (cnt == '0) begin
         case (state)
            BLANK0: begin
               state_nxt = SHOW_ONES;
               cnt_nxt   = SCAN_LD;
            end
            SHOW_ONES: begin
               state_nxt = BLANK1;
               cnt_nxt   = GUARD_LD;
            end
            BLANK1: begin
               state_nxt = SHOW_TENS;
               cnt_nxt   = SCAN_LD;
            end
            default: begin
               state_nxt = BLANK0;
               cnt_nxt   = GUARD_LD;
            end
         endcase
      end
   end

   assign latch = (state == BLANK0) && (cnt == GUARD_LD);

   // The first latch after reset compares against the reset value, so it must not flash.
   always_ff @(posedge clk) begin
      if (rst) begin
         shown     <= 8'h00;
         lz_q      <= 1'b0;
         flash_cnt <= 8'd0;
         first_q   <= 1'b1;
      end else if (latch) begin
         shown   <= bcd_in;
         lz_q    <= blank_lz;
         first_q <= 1'b0;
         if (!first_q && (bcd_in != shown))
            flash_cnt <= FLASH_LD;
         else if (flash_cnt != 8'd0)
            flash_cnt <= flash_cnt - 8'd1;
      end
   end

   // "00" stands for 100 and is always shown in full.
   assign tens_blank = lz_q && (shown[7:4] == 4'd0) && (shown[3:0] != 4'd0);

   always_comb begin
      seg = 7'h00;
      dp  = 1'b0;
      an  = 2'b00;
      case (state)
         SHOW_ONES: begin
            an  = 2'b01;
            seg = seg7(shown[3:0]);
            dp  = (flash_cnt != 8'd0);
         end
         SHOW_TENS: begin
            an  = 2'b10;
            seg = tens_blank ? 7'h00 : seg7(shown[7:4]);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bcd_display_mux.sv
// Bench for bcd_display_mux: fixed vectors, timed scenarios and random stimulus
// compared every cycle against a frame-position model, on a default and a small instance.
module tb_bcd_display_mux;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] bcd_in;
   logic       blank_lz;
   logic [6:0] seg0, seg1;
   logic       dp0, dp1;
   logic [1:0] an0, an1;

   always #5 clk = ~clk;

   bcd_display_mux dut (
      .clk(clk), .rst(rst), .bcd_in(bcd_in), .blank_lz(blank_lz),
      .seg(seg0), .dp(dp0), .an(an0)
   );

   bcd_display_mux #(.SCAN_DIV(3), .GUARD(1)) dut_s (
      .clk(clk), .rst(rst), .bcd_in(bcd_in), .blank_lz(blank_lz),
      .seg(seg1), .dp(dp1), .an(an1)
   );

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: cycle index since reset, position within frame decides the slot.
   localparam int S_P[2] = '{16, 3};
   localparam int G_P[2] = '{2, 1};
   localparam int FLASH  = 8;

   logic [6:0] segs [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   int         m_t     [2];
   logic [7:0] m_shown [2];
   logic       m_lz    [2];
   int         m_flash [2];
   bit         m_first [2];

   function automatic int frame_len(input int i);
      return 2 * (S_P[i] + G_P[i]);
   endfunction

   function automatic logic [6:0] digit_seg(input logic [3:0] n);
      if (n > 4'd9) return 7'h40;
      return segs[n];
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_t[i]     <= 0;
            m_shown[i] <= 8'h00;
            m_lz[i]    <= 1'b0;
            m_flash[i] <= 0;
            m_first[i] <= 1'b1;
         end else begin
            if (m_t[i] % frame_len(i) == 0) begin
               m_shown[i] <= bcd_in;
               m_lz[i]    <= blank_lz;
               m_first[i] <= 1'b0;
               if (!m_first[i] && bcd_in != m_shown[i]) m_flash[i] <= FLASH;
               else if (m_flash[i] > 0)                 m_flash[i] <= m_flash[i] - 1;
            end
            m_t[i] <= m_t[i] + 1;
         end
      end
   end

   function automatic int model_out(input int i);
      int         p;
      logic [6:0] sg;
      logic       d;
      logic [1:0] a;
      p  = m_t[i] % frame_len(i);
      sg = 7'h00;
      d  = 1'b0;
      a  = 2'b00;
      if (p >= G_P[i] && p < G_P[i] + S_P[i]) begin
         a  = 2'b01;
         sg = digit_seg(m_shown[i][3:0]);
         d  = (m_flash[i] != 0);
      end else if (p >= 2 * G_P[i] + S_P[i]) begin
         a  = 2'b10;
         if (m_lz[i] && m_shown[i][7:4] == 4'd0 && m_shown[i][3:0] != 4'd0) sg = 7'h00;
         else sg = digit_seg(m_shown[i][7:4]);
      end
      return int'({sg, d, a});
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_default", int'({seg0, dp0, an0}), model_out(0));
         check("model_small",   int'({seg1, dp1, an1}), model_out(1));
         check("an_not_11",     int'(an0 == 2'b11 || an1 == 2'b11), 0);
         check("seg_off_when_dark",
               int'((an0 == 2'b00 && seg0 != 7'h00) || (an1 == 2'b00 && seg1 != 7'h00)), 0);
      end
   end

   task automatic wait_cyc(input int target);
      int n = 0;
      while (m_t[0] != target && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (m_t[0] != target) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_cyc: reached %0d required %0d", m_t[0], target);
      end
   endtask

   task automatic wait_pos(input int pos);
      int n = 0;
      while (m_t[0] % 36 != pos && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (m_t[0] % 36 != pos) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_pos: reached %0d required %0d", m_t[0] % 36, pos);
      end
   endtask

   // Called at the negedge of cycle 0 with bcd_in=01, blank_lz=1 already applied.
   task automatic scenario_one(input string tag);
      int ea, es;
      for (int c = 0; c < 36; c++) begin
         if (c > 0) @(negedge clk);
         ea = (c < 2) ? 0 : (c < 18) ? 1 : (c < 20) ? 0 : 2;
         es = (ea == 1) ? 'h06 : 'h00;
         check({tag, "_an"},  int'(an0), ea);
         check({tag, "_seg"}, int'(seg0), es);
         check({tag, "_dp"},  int'(dp0), 0);
      end
   endtask

   typedef struct {
      logic [7:0] bcd;
      logic       blz;
      logic [6:0] ones_seg;
      logic [6:0] tens_seg;
   } vec_t;

   vec_t vecs [9];

   initial begin
      vecs[0] = '{8'h20, 1'b1, 7'h3F, 7'h5B};
      vecs[1] = '{8'h00, 1'b1, 7'h3F, 7'h3F};
      vecs[2] = '{8'hA5, 1'b1, 7'h6D, 7'h40};
      vecs[3] = '{8'h05, 1'b1, 7'h6D, 7'h00};
      vecs[4] = '{8'h05, 1'b0, 7'h6D, 7'h3F};
      vecs[5] = '{8'h99, 1'b0, 7'h6F, 7'h6F};
      vecs[6] = '{8'h7F, 1'b1, 7'h40, 7'h07};
      vecs[7] = '{8'h30, 1'b1, 7'h3F, 7'h4F};
      vecs[8] = '{8'h0A, 1'b1, 7'h40, 7'h00};

      rst      = 1'b1;
      bcd_in   = 8'h01;
      blank_lz = 1'b1;
      @(negedge clk);
      chk_en = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_an",  int'(an0), 0);
      check("reset_seg", int'(seg0), 0);
      check("reset_dp",  int'(dp0), 0);

      rst = 1'b0;
      scenario_one("scn1");

      wait_cyc(40);
      bcd_in = 8'h12;
      wait_cyc(70);
      check("hold_old_an",  int'(an0), 2);
      check("hold_old_seg", int'(seg0), 'h00);
      wait_cyc(74);
      check("new_ones_seg", int'(seg0), 'h5B);
      check("flash_start",  int'(dp0), 1);
      wait_cyc(92);
      check("new_tens_seg", int'(seg0), 'h06);
      wait_cyc(326);
      check("flash_last_frame", int'(dp0), 1);
      wait_cyc(362);
      check("flash_over", int'(dp0), 0);
      check("flash_over_an", int'(an0), 1);

      foreach (vecs[k]) begin
         bcd_in   = vecs[k].bcd;
         blank_lz = vecs[k].blz;
         wait_pos(0);
         wait_pos(4);
         check($sformatf("vec%0d_ones_an", k),  int'(an0), 1);
         check($sformatf("vec%0d_ones_seg", k), int'(seg0), int'(vecs[k].ones_seg));
         wait_pos(22);
         check($sformatf("vec%0d_tens_an", k),  int'(an0), 2);
         check($sformatf("vec%0d_tens_seg", k), int'(seg0), int'(vecs[k].tens_seg));
      end

      bcd_in   = 8'h01;
      blank_lz = 1'b1;
      rst      = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      wait_cyc(25);
      check("pre_rst_an", int'(an0), 2);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_an",  int'(an0), 0);
      check("mid_rst_seg", int'(seg0), 0);
      rst = 1'b0;
      scenario_one("after_rst");

      for (int c = 0; c < 6000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 299) == 0) bcd_in = 8'($urandom);
         if ($urandom_range(0, 149) == 0) blank_lz = ~blank_lz;
         rst = ($urandom_range(0, 1999) == 0);
      end
      rst = 1'b0;
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
